// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit hex scanner:
// the display-phase enum and the nibble-to-segment table (bit 0 = a .. bit 6 = g).
package seg7_pkg;

    typedef enum logic [1:0] {
        BLANK_LO,
        SHOW_HI,
        BLANK_HI,
        SHOW_LO
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry [n] holds the segment pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment lookup (active-high, bit 0 = segment a).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_hex_scanner.sv
// Time-multiplexes an 8-bit value as two hex digits on one 7-segment display,
// with blanking gaps between digits and 3-bit PWM brightness. Outputs are registered.
module seg7_hex_scanner
    import seg7_pkg::*;
#(
    parameter int DWELL = 100,
    parameter int BLANK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       load,
    input  logic [2:0] duty,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int MAXN = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int PW   = $clog2(MAXN + 1);
    localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [2:0]      pwm_q;
    logic [7:0]      pending_q, pending_d;
    logic [7:0]      shown_q, shown_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_q, frame_d;

    logic [PW-1:0]   phase_last;
    logic [3:0]      nibble;
    logic [6:0]      digit_seg;
    logic            pwm_on;

    seg7_hex_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (digit_seg)
    );

    assign nibble = (state_q == SHOW_HI) ? shown_q[7:4] : shown_q[3:0];
    assign pwm_on = (pwm_q <= duty);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q + PW'(1);
        pending_d  = load ? value : pending_q;
        shown_d    = shown_q;
        seg_d      = SEG_BLANK;
        dp_d       = 1'b0;
        frame_d    = (state_q == SHOW_HI) && (phase_q == '0);
        phase_last = (state_q == SHOW_HI || state_q == SHOW_LO) ? DWELL_LAST : BLANK_LAST;

        if (phase_q == phase_last) begin
            phase_d = '0;
            unique case (state_q)
                BLANK_LO: state_d = SHOW_HI;
                SHOW_HI:  state_d = BLANK_HI;
                BLANK_HI: state_d = SHOW_LO;
                SHOW_LO:  state_d = BLANK_LO;
                default:  state_d = BLANK_LO;
            endcase
        end

        // Both digits of a frame come from one capture; a load in this very cycle wins.
        if (state_q == BLANK_LO && phase_q == BLANK_LAST)
            shown_d = load ? value : pending_q;

        unique case (state_q)
            SHOW_HI: begin
                if (pwm_on) begin
                    seg_d = digit_seg;
                    dp_d  = 1'b1;
                end
            end
            SHOW_LO: begin
                if (pwm_on) seg_d = digit_seg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BLANK_LO;
            phase_q   <= '0;
            pwm_q     <= 3'd0;
            pending_q <= 8'h00;
            shown_q   <= 8'h00;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pwm_q     <= pwm_q + 3'd1;
            pending_q <= pending_d;
            shown_q   <= shown_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            frame_q   <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_hex_scanner.sv
// Randomized bench for seg7_hex_scanner: a position-in-frame model checks every cycle,
// plus literal pins from hand-worked timelines and a long-dwell PWM count.
module tb_seg7_hex_scanner;

    localparam int D  = 4;
    localparam int B  = 2;
    localparam int P  = 2 * (D + B);
    localparam int D2 = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'h00;
    logic       load = 1'b0;
    logic [2:0] duty = 3'd7;
    logic [6:0] seg, seg2;
    logic       dp, dp2, frame, frame2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg7_hex_scanner #(.DWELL(D), .BLANK(B)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .duty(duty),
        .seg(seg), .dp(dp), .frame(frame)
    );

    seg7_hex_scanner #(.DWELL(D2), .BLANK(B)) dut2 (
        .clk(clk), .rst(rst), .value(value), .load(load), .duty(duty),
        .seg(seg2), .dp(dp2), .frame(frame2)
    );

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: t = cycles since reset; the frame position and PWM phase follow from t.
    int         t = 0;
    int         kr = 0;
    logic [7:0] m_pending = 8'h00;
    logic [7:0] m_shown = 8'h00;
    logic [6:0] e_seg;
    logic       e_dp, e_frame;

    task automatic model_edge();
        int  pos;
        bit  on, hi, lo;
        if (rst) begin
            e_seg = 7'h00; e_dp = 1'b0; e_frame = 1'b0;
            t = 0; m_pending = 8'h00; m_shown = 8'h00;
            return;
        end
        pos = t % P;
        on  = (t % 8) <= int'(duty);
        hi  = (pos >= B) && (pos < B + D);
        lo  = (pos >= 2 * B + D);
        e_seg   = hi ? (on ? tbl[m_shown[7:4]] : 7'h00) :
                  lo ? (on ? tbl[m_shown[3:0]] : 7'h00) : 7'h00;
        e_dp    = hi && on;
        e_frame = (pos == B);
        if (pos == B - 1) m_shown = load ? value : m_pending;
        if (load) m_pending = value;
        t++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        kr = rst ? 0 : kr + 1;
        #1;
        checks++;
        if (seg !== e_seg || dp !== e_dp || frame !== e_frame) begin
            errors++;
            $display("FAIL model k=%0d: got seg=%h dp=%b frame=%b, expected seg=%h dp=%b frame=%b",
                     kr, seg, dp, frame, e_seg, e_dp, e_frame);
        end
    endtask

    task automatic run_to(input int n);
        while (kr < n) step();
    endtask

    task automatic pin(input string name, input logic [6:0] s, input logic d, input logic f);
        checks++;
        if (seg !== s || dp !== d || frame !== f) begin
            errors++;
            $display("FAIL %s: got seg=%h dp=%b frame=%b, expected seg=%h dp=%b frame=%b",
                     name, seg, dp, frame, s, d, f);
        end
    endtask

    initial begin
        int on_cnt, dp_cnt, bad;

        rst = 1'b1;
        step();
        pin("reset", 7'h00, 1'b0, 1'b0);
        rst = 1'b0; duty = 3'd7;

        run_to(1);  pin("blank1", 7'h00, 1'b0, 1'b0);
        run_to(2);  pin("blank2", 7'h00, 1'b0, 1'b0);
        run_to(3);  pin("hi_first", 7'h3F, 1'b1, 1'b1);
        run_to(4);  pin("hi_second", 7'h3F, 1'b1, 1'b0);
        run_to(7);  pin("blank_hi", 7'h00, 1'b0, 1'b0);
        run_to(9);  pin("lo_first", 7'h3F, 1'b0, 1'b0);
        run_to(15); pin("period", 7'h3F, 1'b1, 1'b1);

        value = 8'h3A; load = 1'b1; step(); load = 1'b0;
        run_to(27); pin("load3A_hi", 7'h4F, 1'b1, 1'b1);
        run_to(33); pin("load3A_lo", 7'h77, 1'b0, 1'b0);

        run_to(39); value = 8'h12; load = 1'b1; step(); load = 1'b0;
        pin("atomic_cur_hi", 7'h4F, 1'b1, 1'b0);
        run_to(45); pin("atomic_cur_lo", 7'h77, 1'b0, 1'b0);
        run_to(51); pin("atomic_next_hi", 7'h06, 1'b1, 1'b1);
        run_to(57); pin("atomic_next_lo", 7'h5B, 1'b0, 1'b0);

        run_to(61); value = 8'hEF; load = 1'b1; step(); load = 1'b0;
        run_to(63); pin("edge_load_hi", 7'h79, 1'b1, 1'b1);
        run_to(69); pin("edge_load_lo", 7'h71, 1'b0, 1'b0);

        run_to(70); rst = 1'b1; load = 1'b1; value = 8'h55; step();
        pin("mid_reset", 7'h00, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0;
        run_to(3); pin("post_reset_hi", 7'h3F, 1'b1, 1'b1);
        run_to(9); pin("post_reset_lo", 7'h3F, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 3) == 0);
            value = 8'($urandom);
            if ($urandom_range(0, 15) == 0) duty = 3'($urandom);
            step();
        end
        rst = 1'b0; load = 1'b0;

        // Long-dwell PWM: 40 SHOW_HI cycles at duty 0 light exactly 5 of them.
        rst = 1'b1; step(); rst = 1'b0;
        duty = 3'd0; value = 8'h88; load = 1'b1; step(); load = 1'b0;
        on_cnt = 0; dp_cnt = 0; bad = 0;
        while (kr < 2 + D2) begin
            step();
            if (kr >= 3) begin
                if (seg2 == 7'h7F) on_cnt++;
                else if (seg2 != 7'h00) bad++;
                if (dp2) dp_cnt++;
            end
        end
        checks++;
        if (on_cnt != 5 || dp_cnt != 5 || bad != 0) begin
            errors++;
            $display("FAIL pwm_duty0: got lit=%0d dp=%0d stray=%0d, expected lit=5 dp=5 stray=0",
                     on_cnt, dp_cnt, bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_hex_scanner.md
Name: seg7_hex_scanner

Overview:
- Downstream display stage for the 8-bit counter/LED user module.
- Latches an 8-bit value and shows it as two hex digits, time-multiplexed on one 7-segment display (high digit, then low digit).
- Blanking gaps separate the two digits, and a 3-bit PWM sets brightness.
- Outputs map directly to the 8 io_out pins: {dp, seg[6:0]}.

Parameters:
- DWELL, 100: clock cycles each digit is shown; must be >= 1.
- BLANK, 4: clock cycles of blanking after each digit; must be >= 1.

Ports:
- clk  input  1  clock (the design's single clock).
- rst  input  1  reset: synchronous, active-high.
- value  input  8  value to display.
- load  input  1  single-cycle strobe; captures value.
- duty  input  3  brightness; 0 = dimmest, 7 = fully on.
- seg  output  7  segments, active-high; seg[0]=a … seg[6]=g.
- dp  output  1  decimal point; 1 while the high digit is shown.
- frame  output  1  one-cycle pulse on the first output cycle of each high digit.

Behaviour:
- All outputs are registered.
- Outputs reflect the state and counters of the previous cycle (1-cycle latency).
- Reset (rst=1 at a clock edge):
  - state=BLANK_LO, phase counter=0, pwm counter=0.
  - pending=0x00, shown=0x00.
  - Next-cycle outputs: seg=0, dp=0, frame=0.
- Reset mid-operation aborts the frame immediately and wins over load in the same cycle.
- State machine (cyclic): BLANK_LO(BLANK) -> SHOW_HI(DWELL) -> BLANK_HI(BLANK) -> SHOW_LO(DWELL) -> BLANK_LO.
  - The phase counter counts 0..N-1 in each state; on N-1 it resets to 0 and the state advances.
- load=1 sets pending <= value. Any number of loads per frame is allowed; the last one wins.
- Atomic update: shown <= (load ? value : pending) on the BLANK_LO->SHOW_HI transition only.
  - A load in that exact cycle is displayed in the frame that is starting.
  - The two displayed digits therefore always come from the same captured value.
- SHOW_HI:
  - seg = hexenc(shown[7:4]) gated by PWM; dp=1, also gated by PWM.
- SHOW_LO:
  - seg = hexenc(shown[3:0]) gated by PWM; dp=0.
- BLANK_x: seg=0, dp=0.
- PWM:
  - 3-bit free-running pwm counter, incremented every cycle and wrapping 7->0; reset to 0 only by rst.
  - Segments are enabled when pwm_cnt <= duty.
  - duty=7 means always on; duty=0 means on 1 of 8 cycles.
  - duty is sampled every cycle, with no latching.
- frame = 1 for exactly one output cycle, aligned with the first SHOW_HI output cycle, regardless of PWM gating.
- hexenc (a..g):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Frame period = 2*(DWELL+BLANK) cycles.
- Phase counter width = clog2(max(DWELL,BLANK)+1).

Decomposition:
- Shared package seg7_pkg:
  - state enum: BLANK_LO, SHOW_HI, BLANK_HI, SHOW_LO.
  - 16-entry hex-to-segment constant table.
  - SEG_BLANK = 7'h00.
- One sub-module: seg7_hex_decode (purely combinational nibble -> 7-bit segment lookup).
- FSM, counters and PWM stay in the top module.

Test Plan:
- Reset, then DWELL=4, BLANK=2, duty=7, no load:
  - Cycles 1-2 after reset: seg=00.
  - Next 4 cycles: seg=3F, dp=1, frame=1 on the first only.
  - Then 2 cycles seg=00.
  - Then 4 cycles seg=3F, dp=0.
  - Period is 12 cycles.
- load 0x3A with duty=7:
  - Next frame shows seg=4F with dp=1 for 4 cycles.
  - Then blank, then seg=77 with dp=0.
  - Repeats every frame until the next load.
- Atomic update:
  - load 0x12 during SHOW_HI of a 0x3A frame.
  - Current frame still shows 4F then 77.
  - Following frame shows 06 then 5B.
- Simultaneous boundary: load 0xEF in the BLANK_LO->SHOW_HI transition cycle -> that same frame shows 79 then 71.
- PWM: duty=0, value 0x88, long DWELL -> during SHOW, seg=7F in exactly 1 of every 8 cycles, otherwise 00.
- Reset mid-SHOW_LO with load=1 asserted in the same cycle:
  - Outputs go 0 the next cycle.
  - pending and shown become 00, and the FSM restarts in BLANK_LO.
  - The next frame shows 3F/3F.
